// File: rtl/plru_evict_writeback_if.sv
// Bus bundle for plru_evict_writeback: insert, hit touch, PLRU touch,
// victim input, evict output and status.
interface plru_evict_writeback_if #(
  parameter int unsigned LG2_DEPTH = 3,
  parameter int unsigned DW        = 32
);
  logic                 ins_valid;
  logic                 ins_ready;
  logic [DW-1:0]        ins_data;
  logic [LG2_DEPTH-1:0] victim_idx;
  logic                 hit_valid;
  logic [LG2_DEPTH-1:0] hit_index;
  logic                 hit_ready;
  logic                 touch_valid;
  logic [LG2_DEPTH-1:0] touch_index;
  logic                 evict_valid;
  logic                 evict_ready;
  logic [LG2_DEPTH-1:0] evict_index;
  logic [DW-1:0]        evict_data;
  logic [LG2_DEPTH:0]   occupancy;
  logic                 full;

  modport slave (
    input  ins_valid, ins_data, victim_idx, hit_valid, hit_index, evict_ready,
    output ins_ready, hit_ready, touch_valid, touch_index, evict_valid, evict_index,
           evict_data, occupancy, full
  );

  modport master (
    output ins_valid, ins_data, victim_idx, hit_valid, hit_index, evict_ready,
    input  ins_ready, hit_ready, touch_valid, touch_index, evict_valid, evict_index,
           evict_data, occupancy, full
  );
endinterface

// File: rtl/plru_evict_writeback.sv
// Eviction-side controller for a binary-tree PLRU: fills free slots directly,
// and when full streams the PLRU victim out before refilling that slot.
module plru_evict_writeback #(
  parameter int unsigned LG2_DEPTH = 3,
  parameter int unsigned DW        = 32
) (
  input logic                   clk,
  input logic                   resetn,
  plru_evict_writeback_if.slave bus
);
  localparam int unsigned Depth = 2 ** LG2_DEPTH;

  typedef enum logic [1:0] {StIdle, StEvict, StFill} state_e;

  state_e               state_q, state_d;
  logic [Depth-1:0]     vld_q, vld_d;
  logic [LG2_DEPTH:0]   occ_q, occ_d;
  logic [LG2_DEPTH-1:0] target_q, target_d;
  logic [DW-1:0]        pend_q, pend_d;
  logic [LG2_DEPTH-1:0] evict_index_q, evict_index_d;
  logic [DW-1:0]        evict_data_q, evict_data_d;
  logic [DW-1:0]        mem_q [Depth];

  logic                 full;
  logic                 accept;
  logic                 fill_now;
  logic                 int_touch;
  logic [LG2_DEPTH-1:0] free_idx;

  // Lowest-index free slot; scanning downward leaves the lowest match last.
  always_comb begin
    free_idx = '0;
    for (int i = Depth - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = LG2_DEPTH'(i);
    end
  end

  assign full      = (occ_q == (LG2_DEPTH + 1)'(Depth));
  assign accept    = bus.ins_valid && (state_q == StIdle);
  assign fill_now  = accept && !full;
  assign int_touch = fill_now || (state_q == StFill);

  // Handshake outputs and touch arbitration; internal fills win over hits.
  always_comb begin
    bus.ins_ready   = (state_q == StIdle);
    bus.hit_ready   = !int_touch;
    bus.touch_valid = int_touch || bus.hit_valid;
    bus.touch_index = bus.hit_index;
    if (fill_now) begin
      bus.touch_index = free_idx;
    end else if (state_q == StFill) begin
      bus.touch_index = target_q;
    end
    bus.evict_valid = (state_q == StEvict);
    bus.evict_index = evict_index_q;
    bus.evict_data  = evict_data_q;
    bus.occupancy   = occ_q;
    bus.full        = full;
  end

  // Next-state logic for the FSM and bookkeeping registers.
  always_comb begin
    state_d       = state_q;
    vld_d         = vld_q;
    occ_d         = occ_q;
    target_d      = target_q;
    pend_d        = pend_q;
    evict_index_d = evict_index_q;
    evict_data_d  = evict_data_q;
    unique case (state_q)
      StIdle: begin
        if (fill_now) begin
          vld_d[free_idx] = 1'b1;
          occ_d           = occ_q + 1'b1;
        end else if (accept) begin
          // Victim is sampled now; later changes on victim_idx are ignored.
          target_d      = bus.victim_idx;
          pend_d        = bus.ins_data;
          evict_index_d = bus.victim_idx;
          evict_data_d  = mem_q[bus.victim_idx];
          state_d       = StEvict;
        end
      end
      StEvict: begin
        if (bus.evict_ready) state_d = StFill;
      end
      StFill: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      vld_q         <= '0;
      occ_q         <= '0;
      target_q      <= '0;
      pend_q        <= '0;
      evict_index_q <= '0;
      evict_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      vld_q         <= vld_d;
      occ_q         <= occ_d;
      target_q      <= target_d;
      pend_q        <= pend_d;
      evict_index_q <= evict_index_d;
      evict_data_q  <= evict_data_d;
    end
  end

  // Data store; contents are meaningful only where vld is set.
  always_ff @(posedge clk) begin
    if (fill_now) begin
      mem_q[free_idx] <= bus.ins_data;
    end else if (state_q == StFill) begin
      mem_q[target_q] <= pend_q;
    end
  end
endmodule

// File: tb/tb_plru_evict_writeback.sv
// Directed bench for plru_evict_writeback.
module tb_plru_evict_writeback;
  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  plru_evict_writeback_if #(.LG2_DEPTH(3), .DW(32)) bus ();

  plru_evict_writeback #(.LG2_DEPTH(3), .DW(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    resetn          = 1'b0;
    bus.ins_valid   = 1'b0;
    bus.ins_data    = '0;
    bus.victim_idx  = '0;
    bus.hit_valid   = 1'b0;
    bus.hit_index   = '0;
    bus.evict_ready = 1'b0;
    #12;
    chk("rst_occ", 64'(bus.occupancy), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_evict_valid", 64'(bus.evict_valid), 64'd0);
    chk("rst_evict_index", 64'(bus.evict_index), 64'd0);
    chk("rst_evict_data", 64'(bus.evict_data), 64'd0);
    chk("rst_touch_valid", 64'(bus.touch_valid), 64'd0);
    resetn = 1'b1;
    step();

    // Eight back-to-back fills into slots 0..7.
    for (int i = 0; i < 8; i++) begin
      bus.ins_valid = 1'b1;
      bus.ins_data  = 32'hA0 + 32'(i);
      #1;
      chk("fill_ins_ready", 64'(bus.ins_ready), 64'd1);
      chk("fill_touch_valid", 64'(bus.touch_valid), 64'd1);
      chk("fill_touch_index", 64'(bus.touch_index), 64'(i));
      chk("fill_occ", 64'(bus.occupancy), 64'(i));
      step();
    end
    bus.ins_valid = 1'b0;
    #1;
    chk("full_occ", 64'(bus.occupancy), 64'd8);
    chk("full_flag", 64'(bus.full), 64'd1);
    chk("full_no_evict", 64'(bus.evict_valid), 64'd0);

    // Insert while full, victim 5, downstream stalls for 3 cycles.
    bus.ins_valid  = 1'b1;
    bus.ins_data   = 32'hB5;
    bus.victim_idx = 3'd5;
    #1;
    chk("evacc_ins_ready", 64'(bus.ins_ready), 64'd1);
    chk("evacc_no_touch", 64'(bus.touch_valid), 64'd0);
    step();
    bus.ins_valid  = 1'b0;
    bus.victim_idx = 3'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ev_valid", 64'(bus.evict_valid), 64'd1);
      chk("ev_index", 64'(bus.evict_index), 64'd5);
      chk("ev_data", 64'(bus.evict_data), 64'hA5);
      chk("ev_ins_ready", 64'(bus.ins_ready), 64'd0);
      step();
    end
    bus.evict_ready = 1'b1;
    #1;
    chk("ev_hs_valid", 64'(bus.evict_valid), 64'd1);
    step();
    bus.evict_ready = 1'b0;
    #1;
    chk("fillst_touch_valid", 64'(bus.touch_valid), 64'd1);
    chk("fillst_touch_index", 64'(bus.touch_index), 64'd5);
    chk("fillst_hit_ready", 64'(bus.hit_ready), 64'd0);
    chk("fillst_evict_valid", 64'(bus.evict_valid), 64'd0);
    chk("fillst_ins_ready", 64'(bus.ins_ready), 64'd0);
    step();
    chk("post_ins_ready", 64'(bus.ins_ready), 64'd1);
    chk("post_occ", 64'(bus.occupancy), 64'd8);

    // Evict slot 5 again: its data must now be the refilled 0xB5.
    bus.ins_valid  = 1'b1;
    bus.ins_data   = 32'hB6;
    bus.victim_idx = 3'd5;
    step();
    bus.ins_valid = 1'b0;
    #1;
    chk("ev2_valid", 64'(bus.evict_valid), 64'd1);
    chk("ev2_data", 64'(bus.evict_data), 64'hB5);

    // Reset mid-evict drops everything immediately.
    resetn = 1'b0;
    #1;
    chk("midrst_evict_valid", 64'(bus.evict_valid), 64'd0);
    chk("midrst_occ", 64'(bus.occupancy), 64'd0);
    chk("midrst_full", 64'(bus.full), 64'd0);
    chk("midrst_touch_valid", 64'(bus.touch_valid), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();

    // First insert after reset lands in slot 0 with no eviction.
    bus.ins_valid = 1'b1;
    bus.ins_data  = 32'hC0;
    #1;
    chk("c0_touch_index", 64'(bus.touch_index), 64'd0);
    chk("c0_touch_valid", 64'(bus.touch_valid), 64'd1);
    step();
    chk("c0_no_evict", 64'(bus.evict_valid), 64'd0);
    chk("c0_occ", 64'(bus.occupancy), 64'd1);
    bus.ins_data = 32'hC1;
    step();

    // Hit collides with fill of slot 2; fill wins, hit goes next cycle.
    bus.ins_data  = 32'hC2;
    bus.hit_valid = 1'b1;
    bus.hit_index = 3'd3;
    #1;
    chk("arb_touch_index", 64'(bus.touch_index), 64'd2);
    chk("arb_hit_ready", 64'(bus.hit_ready), 64'd0);
    chk("arb_touch_valid", 64'(bus.touch_valid), 64'd1);
    step();
    bus.ins_valid = 1'b0;
    #1;
    chk("hit_touch_index", 64'(bus.touch_index), 64'd3);
    chk("hit_hit_ready", 64'(bus.hit_ready), 64'd1);
    chk("hit_touch_valid", 64'(bus.touch_valid), 64'd1);
    chk("hit_occ", 64'(bus.occupancy), 64'd3);
    bus.hit_valid = 1'b0;
    #1;
    chk("idle_touch_valid", 64'(bus.touch_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/plru_evict_writeback.md
Name: plru_evict_writeback

Overview:
- Eviction-side controller paired with the binary-tree pseudo-LRU pointer block in the same cache/buffer subsystem.
- Owns a DEPTH-entry data store and accepts insert requests over a valid/ready handshake.
- Fills free slots directly. When full, takes the PLRU victim index, streams the victim entry out over an evict handshake, then refills that slot.
- Drives the PLRU touch interface (din_valid/index) so the tree tracks every fill and every external hit.

Parameters:
- LG2_DEPTH, 3, log2 of entry count; DEPTH = 2**LG2_DEPTH.
- DW, 32, data width of each entry.

Ports:
- clk  input  1  single clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- ins_valid  input  1  insert request valid.
- ins_ready  output  1  insert request accepted when high together with ins_valid.
- ins_data  input  DW  data to insert.
- victim_idx  input  LG2_DEPTH  current PLRU victim, from the tree block's data_evicted.
- hit_valid  input  1  external hit touch request (tag side).
- hit_index  input  LG2_DEPTH  entry that was hit.
- hit_ready  output  1  hit touch accepted this cycle.
- touch_valid  output  1  PLRU update strobe, to the tree block's din_valid.
- touch_index  output  LG2_DEPTH  entry to mark most-recent, to the tree block's index.
- evict_valid  output  1  evicted entry presented.
- evict_ready  input  1  downstream accepts evicted entry.
- evict_index  output  LG2_DEPTH  slot being evicted.
- evict_data  output  DW  data of evicted slot.
- occupancy  output  LG2_DEPTH+1  number of valid entries, 0..DEPTH.
- full  output  1  occupancy == DEPTH.

Behaviour:
- Storage: mem[DEPTH] of DW bits plus a vld[DEPTH] bit vector. Only vld resets; mem contents are don't-care until written.
- Reset (async, resetn low): state=IDLE, vld=0, occupancy=0, full=0, evict_valid=0, evict_index=0, evict_data=0, touch_valid=0. Any pending insert is discarded, including one caught mid-EVICT: nothing is emitted and no touch is issued.
- FSM states IDLE, EVICT, FILL. ins_ready=1 only in IDLE.
- IDLE, accept, not full:
  - Target = lowest index with vld=0.
  - On that clock edge: mem[target]<=ins_data, vld[target]<=1, occupancy+1.
  - touch_valid=1 and touch_index=target, combinationally in the accept cycle.
  - Stay in IDLE, so back-to-back inserts run at one per cycle.
- IDLE, accept, full:
  - Register target<=victim_idx, sampled in the accept cycle, and pend<=ins_data.
  - Register evict_index<=victim_idx and evict_data<=mem[victim_idx]; go to EVICT.
  - No touch is issued in this cycle.
- EVICT:
  - evict_valid=1. evict_index and evict_data stay stable until evict_ready.
  - On evict_valid&&evict_ready: evict_valid<=0 and go to FILL.
  - evict_ready has no required timing; the block waits indefinitely.
- FILL (exactly 1 cycle):
  - mem[target]<=pend, with vld unchanged (still 1) and occupancy unchanged (DEPTH).
  - touch_valid=1, touch_index=target.
  - Next state IDLE.
- Eviction latency: accept at edge N; evict_valid high from cycle N+1; FILL occurs in the cycle after the handshake; ins_ready high again one cycle after FILL.
- Touch arbitration:
  - An internal touch (IDLE fill or FILL) has priority. In that cycle hit_ready=0 and the hit must be held by its source.
  - Otherwise hit_ready=1, and hit_valid forwards to touch_valid with hit_index to touch_index.
  - hit_index is not checked against vld.
- Because touch is combinational, the tree updates at the same edge as the write, so the victim_idx sampled on the next accept already reflects it.
- full = (occupancy == DEPTH); occupancy never exceeds DEPTH and never decrements (no invalidate path).
- The victim is the PLRU choice; a victim equal to the slot just filled is legal and is evicted as-is.

Test Plan:
- Reset, then 8 back-to-back inserts of data 0xA0..0xA7 -> slots 0..7 filled in order, touch_index 0..7 one per cycle, ins_ready held 1, occupancy=8, full=1.
- Full, victim_idx=5, insert 0xB5, evict_ready low 3 cycles -> evict_valid=1 with evict_index=5, evict_data=0xA5 held stable all 3 cycles.
- Same scenario, then evict_ready high -> handshake, then FILL cycle with touch_index=5, then IDLE with ins_ready=1 one cycle later. mem[5]=0xB5, occupancy stays 8.
- hit_valid=1, hit_index=3 in the same cycle as a non-full insert to slot 2 -> touch_index=2, hit_ready=0. Next cycle touch_index=3, hit_ready=1.
- resetn asserted during EVICT -> evict_valid=0 immediately, occupancy=0. After release, an insert of 0xC0 lands in slot 0 with no evict.
- victim_idx changes while in EVICT -> evict_index stays at the value sampled at accept.
